// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the decoder.
//   AW_DEF        default byte-address width
//   opcode_t      3-bit opcode carried in byte0[7:5]
//   LONG_BIT      bit of byte0 that selects the instruction length
//   is_long()     1 when a byte0 starts a two-byte instruction
//   fetch_state_t fetch-stage FSM states
package cpu_pkg;

    localparam int AW_DEF   = 13;
    localparam int LONG_BIT = 7;

    typedef logic [2:0] opcode_t;

    typedef enum logic {
        FETCH0 = 1'b0,
        FETCH1 = 1'b1
    } fetch_state_t;

    // A clear length bit marks a two-byte (long) instruction.
    function automatic logic is_long(input logic [7:0] byte0);
        return !byte0[LONG_BIT];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC and the decoder.
// Drives the PC onto the combinational instruction memory, assembles one- or
// two-byte instructions and presents them through a one-entry output register.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   mem_addr        byte address to instruction memory (the PC register)
//   mem_data        byte at mem_addr, same cycle
//   redirect_valid  branch taken: load redirect_pc, flush everything
//   redirect_pc     branch target
//   instr_valid     output register holds an instruction
//   instr_ready     decoder accepts the instruction this cycle
//   instr_op        opcode, byte0[7:5]
//   instr_addr      operand ({byte0[4:0],byte1} long, zero-extended byte0[4:0] short)
//   instr_long      1 = two-byte instruction
//   instr_pc        address of byte0 of the presented instruction
//   dbg_state       current FSM state
//
// Handshake: an instruction transfers on a cycle where instr_valid and
// instr_ready are both 1. Once instr_valid is raised the payload is held
// stable until that transfer happens; a redirect drops instr_valid without a
// transfer (the instruction is flushed, not consumed).
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int             AW       = AW_DEF,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output opcode_t       instr_op,
    output logic [AW-1:0] instr_addr,
    output logic          instr_long,
    output logic [AW-1:0] instr_pc,
    output fetch_state_t  dbg_state
);

    localparam logic [AW-1:0] PC_ONE = 1;

    fetch_state_t  state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [7:0]    b0, b0_n;
    logic [AW-1:0] b0_pc, b0_pc_n;
    logic          valid_n;
    opcode_t       op_n;
    logic [AW-1:0] addr_n;
    logic          long_n;
    logic [AW-1:0] ipc_n;
    logic          free;
    logic          load;

    assign mem_addr  = pc;
    assign dbg_state = state;

    always_comb begin
        free    = !instr_valid || instr_ready;
        load    = 1'b0;
        state_n = state;
        pc_n    = pc;
        b0_n    = b0;
        b0_pc_n = b0_pc;
        valid_n = instr_valid;
        op_n    = instr_op;
        addr_n  = instr_addr;
        long_n  = instr_long;
        ipc_n   = instr_pc;

        if (redirect_valid) begin
            // Flush: pending byte0 is abandoned and the handshake is ignored.
            pc_n    = redirect_pc;
            state_n = FETCH0;
            valid_n = 1'b0;
        end else begin
            unique case (state)
                FETCH0: begin
                    if (is_long(mem_data)) begin
                        // Byte0 of a long instruction is captured even when
                        // the output slot is busy; only the issue waits.
                        b0_n    = mem_data;
                        b0_pc_n = pc;
                        pc_n    = pc + PC_ONE;
                        state_n = FETCH1;
                    end else if (free) begin
                        load   = 1'b1;
                        op_n   = mem_data[7:5];
                        addr_n = {{(AW-5){1'b0}}, mem_data[4:0]};
                        long_n = 1'b0;
                        ipc_n  = pc;
                        pc_n   = pc + PC_ONE;
                    end
                    // Short and blocked: PC holds so the byte is re-read.
                end
                FETCH1: begin
                    if (free) begin
                        load    = 1'b1;
                        op_n    = b0[7:5];
                        addr_n  = AW'({b0[4:0], mem_data});
                        long_n  = 1'b1;
                        ipc_n   = b0_pc;
                        pc_n    = pc + PC_ONE;
                        state_n = FETCH0;
                    end
                end
                default: state_n = FETCH0;
            endcase

            if (load) begin
                valid_n = 1'b1;
            end else if (instr_valid && instr_ready) begin
                valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH0;
            pc          <= RESET_PC;
            b0          <= '0;
            b0_pc       <= '0;
            instr_valid <= 1'b0;
            instr_op    <= '0;
            instr_addr  <= '0;
            instr_long  <= 1'b0;
            instr_pc    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            b0          <= b0_n;
            b0_pc       <= b0_pc_n;
            instr_valid <= valid_n;
            instr_op    <= op_n;
            instr_addr  <= addr_n;
            instr_long  <= long_n;
            instr_pc    <= ipc_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch with a transaction-level
// reference model (pending-byte queue plus output slot), directed scenarios
// and a randomized phase with stalls, redirects and asynchronous resets.
module tb_instr_fetch;

    localparam int AW = 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [2:0]    instr_op;
    logic [AW-1:0] instr_addr;
    logic          instr_long;
    logic [AW-1:0] instr_pc;
    cpu_pkg::fetch_state_t dbg_state;

    logic [7:0] mem [0:(1<<AW)-1];
    assign mem_data = mem[mem_addr];

    instr_fetch #(.AW(AW), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_addr     (instr_addr),
        .instr_long     (instr_long),
        .instr_pc       (instr_pc),
        .dbg_state      (dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model keeps the bytes collected so far for the next instruction and
    // the instruction sitting in the output slot.
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } frag_t;

    frag_t         m_frag[$];
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic [2:0]    m_op;
    logic [AW-1:0] m_addr;
    logic          m_long;
    logic [AW-1:0] m_ipc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_frag.delete();
            m_pc    = '0;
            m_valid = 1'b0;
            m_op    = '0;
            m_addr  = '0;
            m_long  = 1'b0;
            m_ipc   = '0;
        end else if (redirect_valid) begin
            m_frag.delete();
            m_pc    = redirect_pc;
            m_valid = 1'b0;
        end else begin
            logic       free;
            logic       issued;
            logic [7:0] cand;
            free   = !m_valid || instr_ready;
            issued = 1'b0;
            cand   = mem[m_pc];
            if (m_frag.size() == 0) begin
                if (cand[7] == 1'b0) begin
                    m_frag.push_back('{addr: m_pc, data: cand});
                    m_pc = m_pc + 1;
                end else if (free) begin
                    m_op    = cand[7:5];
                    m_addr  = {8'h00, cand[4:0]};
                    m_long  = 1'b0;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 1;
                    issued  = 1'b1;
                end
            end else if (free) begin
                m_op   = m_frag[0].data[7:5];
                m_addr = {m_frag[0].data[4:0], cand};
                m_long = 1'b1;
                m_ipc  = m_frag[0].addr;
                m_pc   = m_pc + 1;
                m_frag.delete();
                issued = 1'b1;
            end
            if (issued) m_valid = 1'b1;
            else if (m_valid && instr_ready) m_valid = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("mem_addr",    16'(mem_addr),    16'(m_pc));
        chk("instr_valid", 16'(instr_valid), 16'(m_valid));
        chk("instr_op",    16'(instr_op),    16'(m_op));
        chk("instr_addr",  16'(instr_addr),  16'(m_addr));
        chk("instr_long",  16'(instr_long),  16'(m_long));
        chk("instr_pc",    16'(instr_pc),    16'(m_ipc));
        chk("state",       16'(dbg_state),   16'(m_frag.size()));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [AW-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[0]     = 8'h43;
        mem[1]     = 8'hE8;
        mem[2]     = 8'h96;
        mem[3]     = 8'hA1;
        mem[13'h20] = 8'hE8;
        mem[13'h100] = 8'h96;
        mem[13'h101] = 8'h27;
        mem[13'h1FFF] = 8'h01;
        mem[13'h30] = 8'h96;
        mem[13'h31] = 8'h05;

        // Reset state
        repeat (2) step();
        chk("rst_mem_addr", 16'(mem_addr), 16'h0000);
        chk("rst_valid",    16'(instr_valid), 16'h0);
        chk("rst_payload",  16'({instr_op, instr_long}), 16'h0);
        rst = 1'b1;

        // Long pair 0x43,0xE8 then short 0x96, no bubble
        step();
        chk("long_lat_valid", 16'(instr_valid), 16'h0);
        step();
        chk("long_valid", 16'(instr_valid), 16'h1);
        chk("long_op",    16'(instr_op),    16'h2);
        chk("long_addr",  16'(instr_addr),  16'h03E8);
        chk("long_flag",  16'(instr_long),  16'h1);
        chk("long_pc",    16'(instr_pc),    16'h0000);
        step();
        chk("short_valid", 16'(instr_valid), 16'h1);
        chk("short_op",    16'(instr_op),    16'h4);
        chk("short_addr",  16'(instr_addr),  16'h0016);
        chk("short_flag",  16'(instr_long),  16'h0);
        chk("short_pc",    16'(instr_pc),    16'h0002);

        // Stall for 5 cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid",    16'(instr_valid), 16'h1);
            chk("stall_pc",       16'(instr_pc),    16'h0002);
            chk("stall_mem_addr", 16'(mem_addr),    16'h0003);
        end
        instr_ready = 1'b1;
        step();
        chk("release_pc",   16'(instr_pc),   16'h0003);
        chk("release_op",   16'(instr_op),   16'h5);
        chk("release_addr", 16'(instr_addr), 16'h0001);

        // Redirect while b0=0x27 pending in FETCH1 and output valid
        redirect_to(13'h100);
        chk("redir1_valid", 16'(instr_valid), 16'h0);
        chk("redir1_addr",  16'(mem_addr),    16'h0100);
        step();
        chk("redir1_short", 16'(instr_pc), 16'h0100);
        instr_ready = 1'b0;
        step();
        chk("pend_state", 16'(dbg_state),   16'h1);
        chk("pend_valid", 16'(instr_valid), 16'h1);
        instr_ready = 1'b1;
        redirect_to(13'h20);
        chk("flush_valid",    16'(instr_valid), 16'h0);
        chk("flush_mem_addr", 16'(mem_addr),    16'h0020);
        chk("flush_state",    16'(dbg_state),   16'h0);
        step();
        chk("tgt_valid", 16'(instr_valid), 16'h1);
        chk("tgt_op",    16'(instr_op),    16'h7);
        chk("tgt_addr",  16'(instr_addr),  16'h0008);
        chk("tgt_long",  16'(instr_long),  16'h0);
        chk("tgt_pc",    16'(instr_pc),    16'h0020);

        // Long instruction straddling the address wrap
        redirect_to(13'h1FFF);
        chk("wrap_mem_addr0", 16'(mem_addr), 16'h1FFF);
        step();
        chk("wrap_mem_addr1", 16'(mem_addr), 16'h0000);
        step();
        chk("wrap_valid",    16'(instr_valid), 16'h1);
        chk("wrap_op",       16'(instr_op),    16'h0);
        chk("wrap_addr",     16'(instr_addr),  16'h0143);
        chk("wrap_pc",       16'(instr_pc),    16'h1FFF);
        chk("wrap_mem_addr", 16'(mem_addr),    16'h0001);

        // Asynchronous reset while in FETCH1 with output valid
        redirect_to(13'h30);
        step();
        instr_ready = 1'b0;
        step();
        chk("pre_rst_state", 16'(dbg_state),   16'h1);
        chk("pre_rst_valid", 16'(instr_valid), 16'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",    16'(instr_valid), 16'h0);
        chk("arst_mem_addr", 16'(mem_addr),    16'h0000);
        chk("arst_state",    16'(dbg_state),   16'h0);
        chk("arst_pc",       16'(instr_pc),    16'h0000);
        chk("arst_addr",     16'(instr_addr),  16'h0000);
        step();
        rst = 1'b1;
        instr_ready = 1'b1;
        step();
        step();
        chk("restart_valid", 16'(instr_valid), 16'h1);
        chk("restart_pc",    16'(instr_pc),    16'h0000);
        chk("restart_addr",  16'(instr_addr),  16'h03E8);

        // Randomized phase
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 2500; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 2) == 0)
                    redirect_pc = 13'h1FFF - 13'($urandom_range(0, 2));
                else
                    redirect_pc = 13'($urandom_range(0, (1 << AW) - 1));
            end else begin
                redirect_valid = 1'b0;
            end
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
            end else begin
                step();
            end
        end
        redirect_valid = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
